// File: rtl/parking_occupancy_pkg.sv
// Shared constants for the parking occupancy slice: sign FSM encodings,
// default lot sizing and the statistics counter width.
package parking_pkg;

    localparam logic ST_AVAIL = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    localparam int unsigned DEF_CAPACITY = 15;
    localparam int unsigned DEF_HYST     = 2;
    localparam int unsigned STATS_W      = 16;

endpackage

// File: rtl/parking_occupancy_if.sv
// Bus between the occupancy block and its driver (gate FSM / operator panel).
// PARKING_STATS_EN adds the total_in/total_out statistics outputs.
interface parking_occupancy_if
    import parking_pkg::*;
#(
    parameter int unsigned CW = 4
) ();

    logic          enter;
    logic          exit;
    logic          load;
    logic [CW-1:0] load_val;
    logic          err_clr;
    logic [CW-1:0] count;
    logic [CW-1:0] free_spaces;
    logic          empty;
    logic          full_sign;
    logic          ovf_err;
    logic          udf_err;

`ifdef PARKING_STATS_EN
    logic [STATS_W-1:0] total_in;
    logic [STATS_W-1:0] total_out;

    modport master (
        output enter, exit, load, load_val, err_clr,
        input  count, free_spaces, empty, full_sign, ovf_err, udf_err,
        input  total_in, total_out
    );
    modport slave (
        input  enter, exit, load, load_val, err_clr,
        output count, free_spaces, empty, full_sign, ovf_err, udf_err,
        output total_in, total_out
    );
`else
    modport master (
        output enter, exit, load, load_val, err_clr,
        input  count, free_spaces, empty, full_sign, ovf_err, udf_err
    );
    modport slave (
        input  enter, exit, load, load_val, err_clr,
        output count, free_spaces, empty, full_sign, ovf_err, udf_err
    );
`endif

endinterface

// File: rtl/parking_occupancy_counter.sv
// Saturating up/down counter with clamped load; flags the cycle in which an
// increment at MAX or a decrement at zero is rejected.
module occ_sat_counter #(
    parameter int unsigned CW  = 4,
    parameter int unsigned MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic [CW-1:0] o_count,
    output logic          o_ovf_evt,
    output logic          o_udf_evt
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_next;

    // Load beats inc/dec; simultaneous inc and dec cancel with no event.
    always_comb begin
        w_next    = r_count;
        o_ovf_evt = 1'b0;
        o_udf_evt = 1'b0;
        if (i_load) begin
            w_next = (i_load_val > MAX_C) ? MAX_C : i_load_val;
        end else if (i_inc && !i_dec) begin
            if (r_count == MAX_C) o_ovf_evt = 1'b1;
            else                  w_next    = r_count + 1'b1;
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) o_udf_evt = 1'b1;
            else               w_next    = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_count <= '0;
        else        r_count <= w_next;
    end

    assign o_count = r_count;

endmodule

// File: rtl/parking_occupancy.sv
// Lot occupancy tracker: saturating car count, LOT FULL sign with release
// hysteresis, sticky miscount flags. PARKING_STATS_EN adds pulse totals.
module parking_occupancy
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY = DEF_CAPACITY,
    parameter int unsigned HYST     = DEF_HYST
) (
    input logic                clk,
    input logic                reset,
    parking_occupancy_if.slave bus
);

    localparam int unsigned   CW    = $clog2(CAPACITY + 1);
    localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);
    localparam logic [CW-1:0] REL_C = CW'(CAPACITY - HYST);

    logic [CW-1:0] w_count;
    logic          w_ovf_evt;
    logic          w_udf_evt;
    logic          r_state;
    logic          w_state_nxt;
    logic          r_ovf;
    logic          r_udf;

    occ_sat_counter #(
        .CW  (CW),
        .MAX (CAPACITY)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (bus.enter),
        .i_dec      (bus.exit),
        .i_load     (bus.load),
        .i_load_val (bus.load_val),
        .o_count    (w_count),
        .o_ovf_evt  (w_ovf_evt),
        .o_udf_evt  (w_udf_evt)
    );

    always_comb begin
        w_state_nxt = ST_AVAIL;
        case (r_state)
            ST_AVAIL: w_state_nxt = (w_count == CAP_C) ? ST_FULL : ST_AVAIL;
            ST_FULL:  w_state_nxt = (w_count <= REL_C) ? ST_AVAIL : ST_FULL;
            default:  w_state_nxt = ST_AVAIL;
        endcase
    end

    // Error set takes precedence over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_AVAIL;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ovf   <= w_ovf_evt | (r_ovf & ~bus.err_clr);
            r_udf   <= w_udf_evt | (r_udf & ~bus.err_clr);
        end
    end

    assign bus.count       = w_count;
    assign bus.free_spaces = CAP_C - w_count;
    assign bus.empty       = (w_count == '0);
    assign bus.full_sign   = (r_state == ST_FULL);
    assign bus.ovf_err     = r_ovf;
    assign bus.udf_err     = r_udf;

`ifdef PARKING_STATS_EN
    logic [STATS_W-1:0] r_total_in;
    logic [STATS_W-1:0] r_total_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total_in  <= '0;
            r_total_out <= '0;
        end else begin
            if (bus.enter && !bus.load) r_total_in  <= r_total_in + 1'b1;
            if (bus.exit && !bus.load)  r_total_out <= r_total_out + 1'b1;
        end
    end

    assign bus.total_in  = r_total_in;
    assign bus.total_out = r_total_out;
`endif

endmodule

// File: tb/tb_parking_occupancy.sv
// Scoreboard bench for parking_occupancy (CAPACITY 15, HYST 2) plus a
// CAPACITY 10 instance for load clamping. Honours PARKING_STATS_EN.
module tb_parking_occupancy;

    localparam int unsigned CAP  = 15;
    localparam int unsigned HYST = 2;

    typedef struct packed {
        logic [3:0] count;
        logic [3:0] free;
        logic       empty;
        logic       sign;
        logic       ovf;
        logic       udf;
    } exp_t;

    localparam exp_t RST_EXP = '{count: 4'd0, free: 4'd15, empty: 1'b1,
                                 sign: 1'b0, ovf: 1'b0, udf: 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t       sb[$];
    logic [3:0] q2[$];

    logic [3:0] m_count = '0;
    logic       m_sign  = 1'b0;
    logic       m_ovf   = 1'b0;
    logic       m_udf   = 1'b0;
    logic [15:0] m_in   = '0;
    logic [15:0] m_out  = '0;

    parking_occupancy_if #(.CW(4)) bus ();
    parking_occupancy_if #(.CW(4)) bus2 ();

    parking_occupancy #(.CAPACITY(CAP), .HYST(HYST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    parking_occupancy #(.CAPACITY(10), .HYST(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        return '{count: bus.count, free: bus.free_spaces, empty: bus.empty,
                 sign: bus.full_sign, ovf: bus.ovf_err, udf: bus.udf_err};
    endfunction

    task automatic model_reset();
        m_count = '0; m_sign = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        m_in = '0; m_out = '0;
        sb.delete();
    endtask

    // Drives one cycle of stimulus, predicts the post-edge outputs and queues them.
    task automatic apply(input logic en, input logic ex, input logic ld,
                         input logic [3:0] lv, input logic clr);
        exp_t       e;
        logic       ns;
        logic [3:0] nc;
        logic       ov;
        logic       ud;
        @(negedge clk);
        bus.enter = en; bus.exit = ex; bus.load = ld; bus.load_val = lv; bus.err_clr = clr;
        ns = m_sign;
        if (!m_sign && m_count == 4'(CAP))            ns = 1'b1;
        else if (m_sign && m_count <= 4'(CAP - HYST)) ns = 1'b0;
        nc = m_count; ov = 1'b0; ud = 1'b0;
        if (ld) nc = (lv > 4'(CAP)) ? 4'(CAP) : lv;
        else if (en && !ex) begin
            if (m_count == 4'(CAP)) ov = 1'b1; else nc = m_count + 4'd1;
        end else if (ex && !en) begin
            if (m_count == 4'd0) ud = 1'b1; else nc = m_count - 4'd1;
        end
        m_ovf = ov | (m_ovf & ~clr);
        m_udf = ud | (m_udf & ~clr);
        if (en && !ld) m_in  = m_in + 16'd1;
        if (ex && !ld) m_out = m_out + 16'd1;
        m_count = nc;
        m_sign  = ns;
        e = '{count: nc, free: 4'(CAP) - nc, empty: (nc == 4'd0), sign: ns, ovf: m_ovf, udf: m_udf};
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.enter = 1'b0; bus.exit = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        reset = 1'b1;
        #12;
        got = observed();
        checks++;
        if (got !== RST_EXP) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", got, RST_EXP);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_enter3();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL enter3[%0d] got=%h exp=%h", i, observed(), e);
            end
        end
        checks++;
        if (bus.count !== 4'd3 || bus.free_spaces !== 4'd12) begin
            errors++;
            $display("FAIL enter3_final count=%0d free=%0d exp 3/12", bus.count, bus.free_spaces);
        end
    endtask

    task automatic test_fill_overflow();
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            if (i < 12)       apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            else if (i == 12) apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            else              apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL fill[%0d] got=%h exp=%h", i, observed(), e);
            end
        end
        checks++;
        if (bus.count !== 4'd15 || bus.full_sign !== 1'b1 || bus.ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow count=%0d sign=%b ovf=%b exp 15/1/1",
                     bus.count, bus.full_sign, bus.ovf_err);
        end
    endtask

    task automatic test_hysteresis();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            apply(i < 2, 1'b0 == 1'b1 ? 1'b0 : (i < 2), 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL hyst[%0d] got=%h exp=%h", i, observed(), e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, i < 2, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL hyst_exit[%0d] got=%h exp=%h", i, observed(), e);
            end
        end
        checks++;
        if (bus.count !== 4'd13 || bus.full_sign !== 1'b0) begin
            errors++;
            $display("FAIL sign_release count=%0d sign=%b exp 13/0", bus.count, bus.full_sign);
        end
    endtask

    task automatic test_underflow_errclr();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (i < 14)       apply(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
            else if (i == 14) apply(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
            else              apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL underflow[%0d] got=%h exp=%h", i, observed(), e);
            end
            if (i == 14) begin
                checks++;
                if (bus.udf_err !== 1'b1 || bus.ovf_err !== 1'b0) begin
                    errors++;
                    $display("FAIL set_beats_clr udf=%b ovf=%b exp 1/0", bus.udf_err, bus.ovf_err);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       apply(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
                1:       apply(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
                2:       apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
                default: apply(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
            endcase
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL simul[%0d] got=%h exp=%h", i, observed(), e);
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       apply(1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
                1:       apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
                2:       apply(1'b1, 1'b1, 1'b1, 4'd15, 1'b0);
                3:       apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
                4:       apply(1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
                default: apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            endcase
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL load[%0d] got=%h exp=%h", i, observed(), e);
            end
        end
    endtask

    task automatic test_load_clamp();
        logic [3:0] e;
        @(negedge clk);
        bus2.load = 1'b1; bus2.load_val = 4'd13; bus2.enter = 1'b1;
        q2.push_back(4'd10);
        @(posedge clk);
        #1;
        bus2.load = 1'b0; bus2.load_val = '0; bus2.enter = 1'b0;
        e = q2.pop_front();
        checks++;
        if (bus2.count !== e || bus2.free_spaces !== 4'd0 || bus2.ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp count=%0d free=%0d ovf=%b exp %0d/0/0",
                     bus2.count, bus2.free_spaces, bus2.ovf_err, e);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus2.full_sign !== 1'b1) begin
            errors++;
            $display("FAIL load_clamp_sign got=%b exp=1", bus2.full_sign);
        end
    endtask

`ifdef PARKING_STATS_EN
    task automatic test_stats();
        checks++;
        if (bus.total_in !== m_in || bus.total_out !== m_out) begin
            errors++;
            $display("FAIL stats total_in=%0d total_out=%0d exp %0d/%0d",
                     bus.total_in, bus.total_out, m_in, m_out);
        end
    endtask
`endif

    task automatic test_midreset();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL pre_reset[%0d] got=%h exp=%h", i, observed(), e);
            end
        end
        @(negedge clk);
        bus.enter = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (observed() !== RST_EXP) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", observed(), RST_EXP);
        end
`ifdef PARKING_STATS_EN
        checks++;
        if (bus.total_in !== 16'd0 || bus.total_out !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_stats in=%0d out=%0d exp 0/0", bus.total_in, bus.total_out);
        end
`endif
        bus.enter = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.enter = 1'b0; bus.exit = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.err_clr = 1'b0;
        bus2.enter = 1'b0; bus2.exit = 1'b0; bus2.load = 1'b0; bus2.load_val = '0; bus2.err_clr = 1'b0;
        test_reset();
        test_enter3();
        test_fill_overflow();
        test_hysteresis();
        test_underflow_errclr();
        test_simultaneous();
        test_load();
        test_load_clamp();
`ifdef PARKING_STATS_EN
        test_stats();
`endif
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
